// File: rtl/reg_file.sv
// 32 x 32-bit register file: one scoped write port, two enabled combinational
// read ports with write-first forwarding of the merged post-write value.
module reg_file #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] reg_w_index,
    input  logic [DW-1:0] wr_data,
    input  logic          we,
    input  logic [1:0]    wr_scope,
    input  logic [AW-1:0] reg_a_index,
    input  logic          rea,
    input  logic [AW-1:0] reg_b_index,
    input  logic          reb,
    output logic [DW-1:0] rd_value_a,
    output logic [DW-1:0] rd_value_b
);

    localparam int NREG = 2 ** AW;

    logic [DW-1:0] regs [NREG];
    logic          wr_active;
    logic [DW-1:0] wr_mask;
    logic [DW-1:0] wr_merged;

    // Scope 0 is reserved and behaves as no write at all, including for forwarding.
    always_comb begin
        wr_mask = '0;
        unique case (wr_scope)
            2'd1:    wr_mask = DW'(32'h0000_00FF);
            2'd2:    wr_mask = DW'(32'h0000_FFFF);
            2'd3:    wr_mask = '1;
            default: wr_mask = '0;
        endcase
    end

    assign wr_active = we && (wr_scope != 2'd0) && !rst;
    assign wr_merged = (regs[reg_w_index] & ~wr_mask) | (wr_data & wr_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_active) begin
            regs[reg_w_index] <= wr_merged;
        end
    end

    always_comb begin
        rd_value_a = '0;
        if (rea) begin
            rd_value_a = (wr_active && reg_a_index == reg_w_index) ? wr_merged
                                                                    : regs[reg_a_index];
        end
    end

    always_comb begin
        rd_value_b = '0;
        if (reb) begin
            rd_value_b = (wr_active && reg_b_index == reg_w_index) ? wr_merged
                                                                    : regs[reg_b_index];
        end
    end

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: array model of the register contents checked on every
// negedge, plus hand-computed literal reads at key points.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  reg_w_index;
    logic [31:0] wr_data;
    logic        we;
    logic [1:0]  wr_scope;
    logic [4:0]  reg_a_index;
    logic        rea;
    logic [4:0]  reg_b_index;
    logic        reb;
    logic [31:0] rd_value_a;
    logic [31:0] rd_value_b;

    int total = 0;
    int bad = 0;

    logic [31:0] mdl [32];

    reg_file dut (
        .clk(clk),
        .rst(rst),
        .reg_w_index(reg_w_index),
        .wr_data(wr_data),
        .we(we),
        .wr_scope(wr_scope),
        .reg_a_index(reg_a_index),
        .rea(rea),
        .reg_b_index(reg_b_index),
        .reb(reb),
        .rd_value_a(rd_value_a),
        .rd_value_b(rd_value_b)
    );

    always #5 clk = ~clk;

    // What a register holds after a write of the given scope lands on it.
    function automatic logic [31:0] after_write(logic [31:0] old, logic [31:0] d, logic [1:0] sc);
        case (sc)
            2'd1:    return {old[31:8], d[7:0]};
            2'd2:    return {old[31:16], d[15:0]};
            2'd3:    return d;
            default: return old;
        endcase
    endfunction

    function automatic logic [31:0] expect_port(logic re, logic [4:0] idx);
        if (!re || rst) return 32'h0;
        if (we && wr_scope != 2'd0 && idx == reg_w_index)
            return after_write(mdl[idx], wr_data, wr_scope);
        return mdl[idx];
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        end else if (we && wr_scope != 2'd0) begin
            mdl[reg_w_index] = after_write(mdl[reg_w_index], wr_data, wr_scope);
        end
    end

    always @(negedge clk) begin
        chk("model_a", rd_value_a, expect_port(rea, reg_a_index));
        chk("model_b", rd_value_b, expect_port(reb, reg_b_index));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(logic [4:0] idx, logic [31:0] d, logic [1:0] sc);
        we = 1'b1; reg_w_index = idx; wr_data = d; wr_scope = sc;
        tick();
        we = 1'b0;
    endtask

    task automatic read_ab(logic [4:0] ia, logic [4:0] ib);
        rea = 1'b1; reb = 1'b1; reg_a_index = ia; reg_b_index = ib;
        #1;
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; reg_w_index = '0; wr_data = '0; wr_scope = 2'd0;
        reg_a_index = '0; rea = 1'b0; reg_b_index = '0; reb = 1'b0;
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
        tick(); tick();
        rst = 1'b0;

        // reset clears after writes; every index reads zero on both ports
        do_write(5'd4, 32'hCAFE_BABE, 2'd3);
        do_write(5'd31, 32'h1234_5678, 2'd3);
        rst = 1'b1; #1; rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_ab(5'(i), 5'(31 - i));
            chk("reset_a", rd_value_a, 32'h0);
            chk("reset_b", rd_value_b, 32'h0);
        end
        tick();

        do_write(5'd1, 32'h0123_0313, 2'd3);
        read_ab(5'd1, 5'd1);
        chk("word_write", rd_value_a, 32'h0123_0313);

        do_write(5'd2, 32'hFFFF_FFFF, 2'd3);
        do_write(5'd2, 32'h0123_0314, 2'd1);
        read_ab(5'd2, 5'd2);
        chk("byte_write", rd_value_a, 32'hFFFF_FF14);
        do_write(5'd2, 32'h0000_ABCD, 2'd2);
        read_ab(5'd1, 5'd2);
        chk("half_write", rd_value_b, 32'hFFFF_ABCD);

        rea = 1'b0; reb = 1'b0; #1;
        chk("disabled_a", rd_value_a, 32'h0);
        chk("disabled_b", rd_value_b, 32'h0);
        tick();
        rea = 1'b1; reb = 1'b1; #1;
        chk("reenable_a", rd_value_a, 32'h0123_0313);
        chk("reenable_b", rd_value_b, 32'hFFFF_ABCD);
        tick();

        // same-cycle forwarding of a byte write, before the edge
        do_write(5'd5, 32'h1111_1111, 2'd3);
        we = 1'b1; reg_w_index = 5'd5; wr_scope = 2'd1; wr_data = 32'h0000_00AA;
        read_ab(5'd5, 5'd5);
        chk("fwd_a", rd_value_a, 32'h1111_11AA);
        chk("fwd_b", rd_value_b, 32'h1111_11AA);
        tick();
        we = 1'b0; #1;
        chk("fwd_stored", rd_value_a, 32'h1111_11AA);

        do_write(5'd3, 32'h0000_0005, 2'd3);
        we = 1'b1; reg_w_index = 5'd3; wr_scope = 2'd0; wr_data = 32'hFFFF_FFFF;
        read_ab(5'd3, 5'd3);
        chk("scope0_nofwd", rd_value_a, 32'h0000_0005);
        tick();
        we = 1'b0; #1;
        chk("scope0_nowrite", rd_value_b, 32'h0000_0005);
        do_write(5'd0, 32'h0000_0007, 2'd3);
        read_ab(5'd0, 5'd0);
        chk("reg0_a", rd_value_a, 32'h0000_0007);
        chk("reg0_b", rd_value_b, 32'h0000_0007);

        // mid-operation reset: zeros at once, forwarding off, write dropped
        tick();
        read_ab(5'd1, 5'd6);
        #1 rst = 1'b1;
        we = 1'b1; reg_w_index = 5'd6; wr_scope = 2'd3; wr_data = 32'hDEAD_BEEF;
        #1;
        chk("midrst_a", rd_value_a, 32'h0);
        chk("midrst_fwd", rd_value_b, 32'h0);
        tick();
        we = 1'b0; rst = 1'b0; #1;
        chk("rst_write_dropped", rd_value_b, 32'h0);
        tick();

        for (int n = 0; n < 60; n++) begin
            we = 1'($urandom_range(0, 1));
            reg_w_index = 5'($urandom_range(0, 7));
            wr_data = $urandom;
            wr_scope = 2'($urandom_range(0, 3));
            reg_a_index = 5'($urandom_range(0, 7));
            reg_b_index = 5'($urandom_range(0, 7));
            rea = 1'($urandom_range(0, 3) != 0);
            reb = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        we = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
